lcd_value_formatter: RTL and testbench

LCD_VALUE_FORMATTER -- requirements
Module: lcd_value_formatter

---
 rtl/lcd_value_formatter_if.sv | 23 ++
 rtl/lcd_value_formatter.sv | 114 +++++++++++
 tb/tb_lcd_value_formatter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_value_formatter_if.sv
// Host/LCD-driver bus for lcd_value_formatter: conversion handshake,
// static-text write port and registered read port.
interface lcd_value_formatter_if;
   logic [15:0] value;
   logic        load;
   logic        busy;
   logic        done;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [4:0]  rd_addr;
   logic [7:0]  rd_data;

   modport master (
      output value, load, wr_en, wr_addr, wr_data, rd_addr,
      input  busy, done, rd_data
   );

   modport slave (
      input  value, load, wr_en, wr_addr, wr_data, rd_addr,
      output busy, done, rd_data
   );
endinterface

// File: rtl/lcd_value_formatter.sv
// lcd_value_formatter: 32-byte LCD text buffer with a 16-bit binary to
// 5-digit ASCII decimal field writer (double-dabble, 16 shift cycles,
// then 5 digit-write cycles, then a one-cycle done pulse).
// Optional macro LCD_LEADING_ZERO_BLANK_EN: leading zeros written as spaces.
module lcd_value_formatter #(
   parameter int unsigned FIELD_POS = 10
) (
   input logic                  clk,
   input logic                  rst,
   lcd_value_formatter_if.slave bus
);

`ifdef LCD_LEADING_ZERO_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

   state_t      state_q, state_d;
   logic [35:0] sh_q, sh_d;       // {bcd[19:0], bin[15:0]}
   logic [4:0]  cnt_q, cnt_d;
   logic        nz_q, nz_d;       // a nonzero digit has already been written
   logic [7:0]  buf_q [32];
   logic [7:0]  buf_d [32];
   logic [7:0]  rd_data_q, rd_data_d;

   logic [35:0] adj;
   logic [6:0]  dsel;
   logic [3:0]  digit;
   logic [4:0]  waddr;

   // Next-state, conversion datapath and buffer write selection
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      nz_d      = nz_q;
      buf_d     = buf_q;
      rd_data_d = buf_q[bus.rd_addr];
      adj       = sh_q;
      dsel      = 7'd32 - {cnt_q, 2'b00};
      digit     = sh_q[dsel +: 4];
      waddr     = 5'(FIELD_POS) + cnt_q;

      // Host writes are accepted only while no conversion is in flight.
      if (bus.wr_en && (state_q == IDLE || state_q == DONE))
         buf_d[bus.wr_addr] = bus.wr_data;

      case (state_q)
         IDLE: begin
            if (bus.load) begin
               sh_d    = {20'h0, bus.value};
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            for (int unsigned i = 0; i < 5; i++) begin
               if (adj[16 + 4*i +: 4] >= 4'd5)
                  adj[16 + 4*i +: 4] = adj[16 + 4*i +: 4] + 4'd3;
            end
            sh_d  = adj << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
               cnt_d   = '0;
               nz_d    = 1'b0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            // Blank only digits left of the first nonzero; last digit always numeric.
            if (BLANK_EN && !nz_q && digit == 4'd0 && cnt_q != 5'd4)
               buf_d[waddr] = 8'h20;
            else
               buf_d[waddr] = {4'h3, digit};
            nz_d  = nz_q | (digit != 4'd0);
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd4)
               state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath, buffer and read-data registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         cnt_q     <= '0;
         nz_q      <= 1'b0;
         rd_data_q <= '0;
         for (int unsigned i = 0; i < 32; i++)
            buf_q[i] <= 8'h20;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         nz_q      <= nz_d;
         rd_data_q <= rd_data_d;
         buf_q     <= buf_d;
      end
   end

   assign bus.busy    = (state_q == SHIFT) || (state_q == WRITE);
   assign bus.done    = (state_q == DONE);
   assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Directed self-checking bench for lcd_value_formatter (FIELD_POS = 10).
module tb_lcd_value_formatter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned total = 0;
   int unsigned bad   = 0;

   lcd_value_formatter_if bus ();

   lcd_value_formatter #(.FIELD_POS(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #10 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic read_byte(input logic [4:0] a, output logic [7:0] d);
      bus.rd_addr = a;
      tick();
      d = bus.rd_data;
   endtask

   task automatic read_field(output logic [0:4][7:0] f);
      logic [7:0] d;
      for (int k = 0; k < 5; k++) begin
         read_byte(5'(10 + k), d);
         f[k] = d;
      end
   endtask

   task automatic start_load(input logic [15:0] v);
      bus.value = v;
      bus.load  = 1'b1;
      tick();
      bus.load  = 1'b0;
   endtask

   task automatic wait_done(output int unsigned cyc, output bit seen);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         if (bus.done === 1'b1) seen = 1'b1;
         else begin
            tick();
            cyc++;
         end
      end
   endtask

   task automatic test_reset;
      logic [7:0] d;
      rst = 1'b1;
      bus.rd_addr = 5'd0;
      tick();
      tick();
      total++;
      if (bus.rd_data !== 8'h00) begin
         bad++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data);
      end
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++; $display("FAIL reset_busy_done got=%b%b exp=00", bus.busy, bus.done);
      end
      rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         read_byte(5'(a), d);
         total++;
         if (d !== 8'h20) begin
            bad++; $display("FAIL reset_buf[%0d] got=%h exp=20", a, d);
         end
      end
   endtask

   task automatic test_timing;
      logic [0:4][7:0] f;
      logic [0:4][7:0] e;
      e = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      start_load(16'd12345);
      for (int i = 0; i < 21; i++) begin
         total++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++; $display("FAIL timing_busy cycle=%0d got busy=%b done=%b exp busy=1 done=0",
                            i + 1, bus.busy, bus.done);
         end
         tick();
      end
      total++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL timing_done got busy=%b done=%b exp busy=0 done=1", bus.busy, bus.done);
      end
      tick();
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL timing_idle got busy=%b done=%b exp 0 0", bus.busy, bus.done);
      end
      read_field(f);
      for (int k = 0; k < 5; k++) begin
         total++;
         if (f[k] !== e[k]) begin
            bad++; $display("FAIL timing_digit%0d got=%h exp=%h", k, f[k], e[k]);
         end
      end
   endtask

   task automatic test_convert(input string name, input logic [15:0] v, input logic [0:4][7:0] e);
      logic [0:4][7:0] f;
      int unsigned cyc;
      bit seen;
      start_load(v);
      wait_done(cyc, seen);
      total++;
      if (!seen || cyc != 21) begin
         bad++; $display("FAIL %s_done got seen=%0d cyc=%0d exp seen=1 cyc=21", name, seen, cyc);
      end
      tick();
      read_field(f);
      for (int k = 0; k < 5; k++) begin
         total++;
         if (f[k] !== e[k]) begin
            bad++; $display("FAIL %s_digit%0d got=%h exp=%h", name, k, f[k], e[k]);
         end
      end
   endtask

   task automatic test_host_write;
      logic [7:0] d;
      logic [0:4][7:0] f;
      logic [0:4][7:0] e;
      int unsigned cyc;
      bit seen;
`ifdef LCD_LEADING_ZERO_BLANK_EN
      e = {8'h20, 8'h20, 8'h31, 8'h30, 8'h30};
`else
      e = {8'h30, 8'h30, 8'h31, 8'h30, 8'h30};
`endif
      bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 8'h55;
      tick();
      bus.wr_en = 1'b0;
      read_byte(5'd0, d);
      total++;
      if (d !== 8'h55) begin
         bad++; $display("FAIL hw_idle got=%h exp=55", d);
      end
      // read and write the same index in one cycle: old byte first
      bus.rd_addr = 5'd0;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 8'h66;
      tick();
      bus.wr_en = 1'b0;
      total++;
      if (bus.rd_data !== 8'h55) begin
         bad++; $display("FAIL hw_rdw_old got=%h exp=55", bus.rd_data);
      end
      tick();
      total++;
      if (bus.rd_data !== 8'h66) begin
         bad++; $display("FAIL hw_rdw_new got=%h exp=66", bus.rd_data);
      end
      // writes while busy are dropped
      start_load(16'd100);
      for (int i = 0; i < 20; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_addr = (i < 10) ? 5'd1 : 5'd31;
         bus.wr_data = 8'h55;
         tick();
      end
      bus.wr_en = 1'b0;
      wait_done(cyc, seen);
      total++;
      if (!seen) begin
         bad++; $display("FAIL hw_busy_done got seen=0 exp seen=1");
      end
      // write during DONE is accepted
      bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 8'h41;
      tick();
      bus.wr_en = 1'b0;
      read_byte(5'd1, d);
      total++;
      if (d !== 8'h20) begin
         bad++; $display("FAIL hw_busy_addr1 got=%h exp=20", d);
      end
      read_byte(5'd31, d);
      total++;
      if (d !== 8'h20) begin
         bad++; $display("FAIL hw_busy_addr31 got=%h exp=20", d);
      end
      read_byte(5'd2, d);
      total++;
      if (d !== 8'h41) begin
         bad++; $display("FAIL hw_done_addr2 got=%h exp=41", d);
      end
      read_byte(5'd0, d);
      total++;
      if (d !== 8'h66) begin
         bad++; $display("FAIL hw_keep_addr0 got=%h exp=66", d);
      end
      read_byte(5'd9, d);
      total++;
      if (d !== 8'h20) begin
         bad++; $display("FAIL hw_neighbor9 got=%h exp=20", d);
      end
      read_byte(5'd15, d);
      total++;
      if (d !== 8'h20) begin
         bad++; $display("FAIL hw_neighbor15 got=%h exp=20", d);
      end
      read_field(f);
      for (int k = 0; k < 5; k++) begin
         total++;
         if (f[k] !== e[k]) begin
            bad++; $display("FAIL hw_digit%0d got=%h exp=%h", k, f[k], e[k]);
         end
      end
   endtask

   task automatic test_load_ignored;
      logic [0:4][7:0] f;
      int unsigned cyc;
      bit seen;
      start_load(16'd11111);
      tick(); tick(); tick();
      bus.value = 16'd22222;
      bus.load  = 1'b1;
      tick();
      bus.load  = 1'b0;
      wait_done(cyc, seen);
      total++;
      if (!seen || cyc != 17) begin
         bad++; $display("FAIL ign_done got seen=%0d cyc=%0d exp seen=1 cyc=17", seen, cyc);
      end
      tick();
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL ign_idle got busy=%b exp 0", bus.busy);
      end
      read_field(f);
      for (int k = 0; k < 5; k++) begin
         total++;
         if (f[k] !== 8'h31) begin
            bad++; $display("FAIL ign_digit%0d got=%h exp=31", k, f[k]);
         end
      end
   endtask

   task automatic test_reset_abort(input string name, input int unsigned pre);
      logic [7:0] d;
      bit saw_done;
      start_load(16'd54321);
      for (int unsigned i = 0; i < pre; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++; $display("FAIL %s_busy got busy=%b done=%b exp 0 0", name, bus.busy, bus.done);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
         tick();
      end
      total++;
      if (saw_done) begin
         bad++; $display("FAIL %s_quiet got activity=1 exp 0", name);
      end
      for (int a = 0; a < 32; a++) begin
         read_byte(5'(a), d);
         total++;
         if (d !== 8'h20) begin
            bad++; $display("FAIL %s_buf[%0d] got=%h exp=20", name, a, d);
         end
      end
   endtask

   initial begin
      bus.value   = '0;
      bus.load    = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;
      #1;
      test_reset();
      test_timing();
`ifdef LCD_LEADING_ZERO_BLANK_EN
      test_convert("zero", 16'd0,   {8'h20, 8'h20, 8'h20, 8'h20, 8'h30});
      test_convert("v700", 16'd700, {8'h20, 8'h20, 8'h37, 8'h30, 8'h30});
      test_convert("v9",   16'd9,   {8'h20, 8'h20, 8'h20, 8'h20, 8'h39});
`else
      test_convert("zero", 16'd0,   {8'h30, 8'h30, 8'h30, 8'h30, 8'h30});
      test_convert("v700", 16'd700, {8'h30, 8'h30, 8'h37, 8'h30, 8'h30});
      test_convert("v9",   16'd9,   {8'h30, 8'h30, 8'h30, 8'h30, 8'h39});
`endif
      test_convert("max",  16'd65535, {8'h36, 8'h35, 8'h35, 8'h33, 8'h35});
      test_convert("v40960", 16'd40960, {8'h34, 8'h30, 8'h39, 8'h36, 8'h30});
      test_host_write();
      test_load_ignored();
      test_reset_abort("abort_shift", 4);
      test_reset_abort("abort_write", 18);
      test_convert("after_abort", 16'd54321, {8'h35, 8'h34, 8'h33, 8'h32, 8'h31});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
